ber_test_sequencer: RTL and testbench

Controls one bit-error test run for a receive lane. After a start command, it waits until the toggle detector's toggle_flag shows a live link. It then counts valid bits and compare errors over a programmed window and reports pass/fail. It sits between the host control registers and the toggle-detector/comparator datapath.

---
 rtl/ber_test_sequencer_if.sv | 33 +++
 rtl/ber_test_sequencer.sv | 193 +++++++++++++++++++
 tb/tb_ber_test_sequencer.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ber_test_sequencer_if.sv
// Host/datapath bundle for the BER test sequencer: control, bit stream and status.
interface ber_test_sequencer_if #(
  parameter int CNT_W = 32,
  parameter int ERR_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] test_length;
  logic             bit_valid;
  logic             bit_err;
  logic             toggle_flag;
  logic             busy;
  logic             done;
  logic             result_valid;
  logic             pass;
  logic             sync_fault;
  logic             stuck_fault;
  logic [CNT_W-1:0] bit_count;
  logic [ERR_W-1:0] error_count;
  logic [2:0]       state;

  modport master (
    output start, abort, test_length, bit_valid, bit_err, toggle_flag,
    input  busy, done, result_valid, pass, sync_fault, stuck_fault,
           bit_count, error_count, state
  );

  modport slave (
    input  start, abort, test_length, bit_valid, bit_err, toggle_flag,
    output busy, done, result_valid, pass, sync_fault, stuck_fault,
           bit_count, error_count, state
  );
endinterface

// File: rtl/ber_test_sequencer.sv
// BER run control: SYNC on toggles, count bits/errors over a window, report pass; BER_STUCK_WATCHDOG_EN adds a stuck-link watchdog.
// Latency: every output is registered, reacting one clock after the causing input.
// Backpressure: none; bit_valid is consumed every cycle it is high, start is dropped while busy.
module ber_test_sequencer #(
  parameter int CNT_W        = 32,
  parameter int ERR_W        = 16,
  parameter int SYNC_TOGGLES = 8,
  parameter int SYNC_TIMEOUT = 1024,
  parameter int STUCK_LIMIT  = 256,
  parameter int TOL_ERR      = 0
) (
  input logic                  clk,
  input logic                  reset,
  ber_test_sequencer_if.slave  bus
);

  localparam int TMR_W = $clog2(SYNC_TIMEOUT + 1);
  localparam int TOG_W = $clog2(SYNC_TOGGLES + 1);
  localparam logic [TMR_W-1:0] SYNC_LAST = TMR_W'(SYNC_TIMEOUT - 1);
  localparam logic [TOG_W-1:0] TOG_LAST  = TOG_W'(SYNC_TOGGLES - 1);
  localparam logic [ERR_W-1:0] ERR_MAX   = '1;
  localparam logic [ERR_W-1:0] ERR_TOL   = ERR_W'(TOL_ERR);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SYNC  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  state_t           state_q, state_nxt;
  logic [CNT_W-1:0] len_q, len_nxt;
  logic [CNT_W-1:0] bc_q, bc_nxt, bc_inc;
  logic [ERR_W-1:0] ec_q, ec_nxt, ec_inc;
  logic [TMR_W-1:0] tmr_q, tmr_nxt;
  logic [TOG_W-1:0] tog_q, tog_nxt;
  logic             busy_q, done_q, done_nxt;
  logic             rv_q, rv_nxt, pass_q, pass_nxt;
  logic             sfault_q, sfault_nxt;

`ifdef BER_STUCK_WATCHDOG_EN
  localparam int STK_W = $clog2(STUCK_LIMIT + 1);
  localparam logic [STK_W-1:0] STUCK_LAST = STK_W'(STUCK_LIMIT - 1);
  logic [STK_W-1:0] stk_q, stk_nxt;
  logic             kfault_q, kfault_nxt;
`endif

  always_comb begin
    state_nxt  = state_q;
    len_nxt    = len_q;
    bc_nxt     = bc_q;
    ec_nxt     = ec_q;
    tmr_nxt    = tmr_q;
    tog_nxt    = tog_q;
    done_nxt   = 1'b0;
    rv_nxt     = rv_q;
    pass_nxt   = pass_q;
    sfault_nxt = sfault_q;
    bc_inc     = bc_q + CNT_W'(1);
    ec_inc     = (ec_q == ERR_MAX) ? ec_q : ec_q + ERR_W'(1);
`ifdef BER_STUCK_WATCHDOG_EN
    stk_nxt    = stk_q;
    kfault_nxt = kfault_q;
`endif

    // abort outranks start, completion and faults alike; counters are left as they are
    if (bus.abort) begin
      state_nxt  = S_IDLE;
      rv_nxt     = 1'b0;
      pass_nxt   = 1'b0;
      sfault_nxt = 1'b0;
`ifdef BER_STUCK_WATCHDOG_EN
      kfault_nxt = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_FAULT: begin
          if (bus.start) begin
            len_nxt    = bus.test_length;
            bc_nxt     = '0;
            ec_nxt     = '0;
            tmr_nxt    = '0;
            tog_nxt    = '0;
            rv_nxt     = 1'b0;
            pass_nxt   = 1'b0;
            sfault_nxt = 1'b0;
`ifdef BER_STUCK_WATCHDOG_EN
            stk_nxt    = '0;
            kfault_nxt = 1'b0;
`endif
            if (bus.test_length == '0) begin
              state_nxt = S_DONE;
              done_nxt  = 1'b1;
              rv_nxt    = 1'b1;
              pass_nxt  = 1'b1;
            end else begin
              state_nxt = S_SYNC;
            end
          end
        end
        S_SYNC: begin
          tmr_nxt = tmr_q + TMR_W'(1);
          if (bus.toggle_flag)
            tog_nxt = tog_q + TOG_W'(1);
          if (bus.toggle_flag && tog_q == TOG_LAST) begin
            state_nxt = S_RUN;
          end else if (tmr_q == SYNC_LAST) begin
            state_nxt  = S_FAULT;
            sfault_nxt = 1'b1;
          end
        end
        S_RUN: begin
`ifdef BER_STUCK_WATCHDOG_EN
          stk_nxt = bus.toggle_flag ? '0 : stk_q + STK_W'(1);
`endif
          if (bus.bit_valid) begin
            bc_nxt = bc_inc;
            if (bus.bit_err)
              ec_nxt = ec_inc;
          end
          if (bus.bit_valid && bc_inc == len_q) begin
            state_nxt = S_DONE;
            done_nxt  = 1'b1;
            rv_nxt    = 1'b1;
            pass_nxt  = (ec_nxt <= ERR_TOL);
          end
`ifdef BER_STUCK_WATCHDOG_EN
          else if (!bus.toggle_flag && stk_q == STUCK_LAST) begin
            state_nxt  = S_FAULT;
            kfault_nxt = 1'b1;
          end
`endif
        end
        S_DONE:  state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      bc_q     <= '0;
      ec_q     <= '0;
      tmr_q    <= '0;
      tog_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rv_q     <= 1'b0;
      pass_q   <= 1'b0;
      sfault_q <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      len_q    <= len_nxt;
      bc_q     <= bc_nxt;
      ec_q     <= ec_nxt;
      tmr_q    <= tmr_nxt;
      tog_q    <= tog_nxt;
      busy_q   <= (state_nxt == S_SYNC) || (state_nxt == S_RUN);
      done_q   <= done_nxt;
      rv_q     <= rv_nxt;
      pass_q   <= pass_nxt;
      sfault_q <= sfault_nxt;
    end
  end

`ifdef BER_STUCK_WATCHDOG_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stk_q    <= '0;
      kfault_q <= 1'b0;
    end else begin
      stk_q    <= stk_nxt;
      kfault_q <= kfault_nxt;
    end
  end
  assign bus.stuck_fault = kfault_q;
`else
  assign bus.stuck_fault = 1'b0;
`endif

  assign bus.state        = state_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.result_valid = rv_q;
  assign bus.pass         = pass_q;
  assign bus.sync_fault   = sfault_q;
  assign bus.bit_count    = bc_q;
  assign bus.error_count  = ec_q;

endmodule

// File: tb/tb_ber_test_sequencer.sv
// Directed + randomized bench for ber_test_sequencer; expectations come from bit/error tallies kept here.
module tb_ber_test_sequencer;
  localparam int CNT_W = 32, ERR_W = 4, SYNC_TOGGLES = 8, SYNC_TIMEOUT = 16;
  localparam int STUCK_LIMIT = 8, TOL_ERR = 2, ERR_MAX = 15;
  localparam int ST_IDLE = 0, ST_SYNC = 1, ST_RUN = 2, ST_DONE = 3, ST_FAULT = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_assert = 0;
  int   n_fail = 0;

  ber_test_sequencer_if #(.CNT_W(CNT_W), .ERR_W(ERR_W)) bus ();

  ber_test_sequencer #(
    .CNT_W(CNT_W), .ERR_W(ERR_W), .SYNC_TOGGLES(SYNC_TOGGLES), .SYNC_TIMEOUT(SYNC_TIMEOUT),
    .STUCK_LIMIT(STUCK_LIMIT), .TOL_ERR(TOL_ERR)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.abort = 0; bus.test_length = '0;
    bus.bit_valid = 0; bus.bit_err = 0; bus.toggle_flag = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_state"}, bus.state, 0);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_rv"}, bus.result_valid, 0);
    check({tag, "_pass"}, bus.pass, 0);
    check({tag, "_sfault"}, bus.sync_fault, 0);
    check({tag, "_kfault"}, bus.stuck_fault, 0);
    check({tag, "_bc"}, bus.bit_count, 0);
    check({tag, "_ec"}, bus.error_count, 0);
  endtask

  task automatic start_run(input int len);
    bus.start = 1; bus.test_length = CNT_W'(len);
    tick();
    bus.start = 0;
    check("start_state", bus.state, (len == 0) ? ST_DONE : ST_SYNC);
    check("start_busy", bus.busy, (len == 0) ? 0 : 1);
  endtask

  // mode 0: toggle every cycle; 1: random toggles; 2: 8 quiet then 8 toggles (RUN on the timeout cycle)
  task automatic sync_phase(input int mode);
    int t = 0;
    int c = 0;
    bit tg;
    while (t < SYNC_TOGGLES && c < SYNC_TIMEOUT) begin
      if (mode == 0) tg = 1;
      else if (mode == 2) tg = (c >= SYNC_TIMEOUT - SYNC_TOGGLES);
      else tg = ($urandom_range(0, 1) == 1) || (SYNC_TIMEOUT - c <= SYNC_TOGGLES - t);
      bus.toggle_flag = tg;
      bus.bit_valid = 1'($urandom_range(0, 1));
      bus.bit_err = 1'($urandom_range(0, 1));
      tick();
      c++;
      if (tg) t++;
      check("sync_state", bus.state, (t == SYNC_TOGGLES) ? ST_RUN : ST_SYNC);
      check("sync_bc", bus.bit_count, 0);
    end
    bus.bit_valid = 0; bus.bit_err = 0; bus.toggle_flag = 1;
  endtask

  // Bits n0+1..len; bit i carries an error when errv[i-1]; toggle_flag every 'period' cycles.
  task automatic run_bits(input int len, input int n0, input int e0, input logic [127:0] errv,
                          input bit gaps, input int period);
    int n = n0;
    int e = e0;
    int k = 0;
    bit v;
    while (n < len) begin
      v = !gaps || ($urandom_range(0, 2) != 0);
      bus.bit_valid = v;
      bus.bit_err = v ? errv[n] : 1'($urandom_range(0, 1));
      bus.toggle_flag = ((k % period) == period - 1);
      tick();
      k++;
      if (v) begin
        if (errv[n]) e++;
        n++;
      end
      check("run_bc", bus.bit_count, n);
      check("run_ec", bus.error_count, (e > ERR_MAX) ? ERR_MAX : e);
      check("run_state", bus.state, (n == len) ? ST_DONE : ST_RUN);
      check("run_done", bus.done, (n == len) ? 1 : 0);
    end
    bus.bit_valid = 0; bus.bit_err = 0; bus.toggle_flag = 0;
    check("fin_rv", bus.result_valid, 1);
    check("fin_pass", bus.pass, (e <= TOL_ERR) ? 1 : 0);
    check("fin_busy", bus.busy, 0);
    tick();
    check("post_state", bus.state, ST_IDLE);
    check("post_done", bus.done, 0);
    check("post_rv", bus.result_valid, 1);
    check("post_bc", bus.bit_count, len);
  endtask

  task automatic timeout_to_fault();
    start_run(5);
    bus.toggle_flag = 0;
    for (int c = 1; c <= SYNC_TIMEOUT; c++) begin
      tick();
      check("to_state", bus.state, (c == SYNC_TIMEOUT) ? ST_FAULT : ST_SYNC);
    end
    check("to_sfault", bus.sync_fault, 1);
    check("to_busy", bus.busy, 0);
    check("to_rv", bus.result_valid, 0);
  endtask

  initial begin
    logic [127:0] ev;
    int len;
    idle_inputs();
    repeat (2) tick();
    check_zero("reset");
    reset = 0;
    tick();

    // basic pass, then errors against tolerance (bits 10/20/30; then 10 and the final bit 50)
    start_run(100); sync_phase(0); run_bits(100, 0, 0, '0, 0, 1);
    ev = '0; ev[9] = 1; ev[19] = 1; ev[29] = 1;
    start_run(50); sync_phase(1); run_bits(50, 0, 0, ev, 1, 1);
    ev = '0; ev[9] = 1; ev[49] = 1;
    start_run(50); sync_phase(2); run_bits(50, 0, 0, ev, 0, 1);

    // start+abort together in IDLE: abort wins, result cleared, counters kept
    bus.start = 1; bus.abort = 1; bus.test_length = 7;
    tick();
    bus.start = 0; bus.abort = 0;
    check("sa_state", bus.state, ST_IDLE);
    check("sa_rv", bus.result_valid, 0);
    check("sa_bc", bus.bit_count, 50);
    check("sa_ec", bus.error_count, 2);

    // sync timeout, FAULT holds, restart clears flag, abort from SYNC
    timeout_to_fault();
    bus.toggle_flag = 1;
    repeat (3) tick();
    check("fault_hold", bus.state, ST_FAULT);
    check("fault_hold_sf", bus.sync_fault, 1);
    start_run(5);
    check("restart_sf", bus.sync_fault, 0);
    bus.abort = 1; tick(); bus.abort = 0;
    check("abort_sync", bus.state, ST_IDLE);
    timeout_to_fault();
    bus.abort = 1; tick(); bus.abort = 0;
    check("abort_fault", bus.state, ST_IDLE);
    check("abort_fault_sf", bus.sync_fault, 0);

    // saturation and abort mid-run
    start_run(60); sync_phase(0);
    for (int i = 1; i <= 40; i++) begin
      bus.bit_valid = 1; bus.bit_err = 1;
      tick();
      check("sat_ec", bus.error_count, (i > ERR_MAX) ? ERR_MAX : i);
    end
    bus.bit_valid = 0; bus.bit_err = 0; bus.abort = 1;
    tick();
    bus.abort = 0;
    check("sat_state", bus.state, ST_IDLE);
    check("sat_rv", bus.result_valid, 0);
    check("sat_bc", bus.bit_count, 40);
    check("sat_busy", bus.busy, 0);

    // zero-length run
    start_run(0);
    check("zl_done", bus.done, 1);
    check("zl_pass", bus.pass, 1);
    check("zl_rv", bus.result_valid, 1);
    check("zl_bc", bus.bit_count, 0);
    tick();
    check("zl_idle", bus.state, ST_IDLE);
    check("zl_done2", bus.done, 0);

    // start while RUN is ignored
    start_run(20); sync_phase(0);
    for (int i = 0; i < 5; i++) begin bus.bit_valid = 1; tick(); end
    bus.start = 1; bus.test_length = 2;
    tick();
    bus.start = 0;
    check("sr_state", bus.state, ST_RUN);
    check("sr_bc", bus.bit_count, 6);
    run_bits(20, 6, 0, '0, 1, 1);

    // abort on the final bit: no done pulse
    start_run(4); sync_phase(0);
    for (int i = 0; i < 3; i++) begin bus.bit_valid = 1; tick(); end
    bus.abort = 1;
    tick();
    bus.abort = 0; bus.bit_valid = 0;
    check("af_state", bus.state, ST_IDLE);
    check("af_done", bus.done, 0);
    check("af_rv", bus.result_valid, 0);
    check("af_bc", bus.bit_count, 3);
    tick();
    check("af_done2", bus.done, 0);

    // random runs
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, 40);
      for (int i = 0; i < 128; i++) ev[i] = ($urandom_range(0, 7) == 0);
      start_run(len); sync_phase(1); run_bits(len, 0, 0, ev, 1, $urandom_range(1, 8));
    end

    // quiet link: 7 quiet + toggle completes; completion beats the watchdog on the same cycle
    start_run(30); sync_phase(0); run_bits(30, 0, 0, '0, 1, 8);
    start_run(8); sync_phase(0); run_bits(8, 0, 0, '0, 0, 1000);

    start_run(50); sync_phase(0);
    bus.toggle_flag = 0;
`ifdef BER_STUCK_WATCHDOG_EN
    for (int c = 1; c <= STUCK_LIMIT; c++) begin
      bus.bit_valid = 1;
      tick();
      check("wd_state", bus.state, (c == STUCK_LIMIT) ? ST_FAULT : ST_RUN);
    end
    check("wd_kfault", bus.stuck_fault, 1);
    check("wd_busy", bus.busy, 0);
    check("wd_bc", bus.bit_count, STUCK_LIMIT);
`else
    for (int c = 1; c <= 20; c++) begin
      bus.bit_valid = 1;
      tick();
      check("nowd_state", bus.state, ST_RUN);
    end
    check("nowd_kfault", bus.stuck_fault, 0);
`endif
    bus.bit_valid = 0; bus.abort = 1;
    tick();
    bus.abort = 0;
    check("wd_abort", bus.state, ST_IDLE);
    check("wd_abort_kf", bus.stuck_fault, 0);

    // asynchronous reset mid-RUN
    start_run(40); sync_phase(0);
    for (int i = 0; i < 5; i++) begin bus.bit_valid = 1; bus.bit_err = 1; tick(); end
    #2 reset = 1;
    #1 check_zero("mid_reset");
    idle_inputs();
    tick();
    reset = 0;
    tick();
    check_zero("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
